stage5_field_extract_pipe: RTL and testbench
============================================

Name: stage5_field_extract_pipe

Overview:
- Parametrised, pipelined successor to the stage-5 per-field extractor.
- For each of NUM_CH independent message channels, it selects one field from the message according to that message's type code (a/d/k/q), or substitutes DEFAULT.
- Each result is buffered in a 2-entry per-channel skid FIFO with valid/ready handshakes, so stage 4 and stage 6 can stall independently.
- Per-channel saturating hit/miss counters feed debug readout.

Parameters:
- NUM_CH, 3, number of message channels.
- MSG_BITS, `MAX_MESSAGE_BITS, width of one message.
- CTRL_W, `message_mux_control_width, width of one type code.
- FIELD_BITS, `field_EB3_bits, width of the extracted field.
- A_LSB / D_LSB / K_LSB / Q_LSB, `a_EB3_e / `d_EB3_e / `k_EB3_e / `q_EB3_e, LSB of the field for each type; the field spans [x_LSB+FIELD_BITS-1 : x_LSB].
- TYPE_A / TYPE_D / TYPE_K / TYPE_Q, `message_mux_a / _d / _k / _q, type code values.
- DEFAULT, `defaut_infor, substitute field value.
- CNT_W, 16, counter width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- message_en  in  1  global extract enable, sampled together with each accepted message.
- in_valid  in  NUM_CH  per-channel message valid.
- in_ready  out  NUM_CH  per-channel FIFO can accept.
- message_bus  in  NUM_CH*MSG_BITS  channel i at [i*MSG_BITS +: MSG_BITS].
- mux_control_bus  in  NUM_CH*CTRL_W  channel i type code.
- out_valid  out  NUM_CH  head entry valid.
- out_ready  in  NUM_CH  downstream accepts.
- field_bus  out  NUM_CH*FIELD_BITS  head field per channel.
- field_hit  out  NUM_CH  head entry type was known and message_en was 1.
- cnt_clr  in  1  synchronous clear of all counters.
- hit_cnt_bus  out  NUM_CH*CNT_W  accepted known-type messages per channel.
- miss_cnt_bus  out  NUM_CH*CNT_W  accepted unknown-type messages per channel.

Behaviour:
- Reset: all FIFOs empty, out_valid=0, field_bus=0, field_hit=0, counters=0. in_ready is forced to 0 while rst=1, and rises in the first cycle after deassertion. Reset asserted mid-transfer drops all buffered entries; there is no partial output.
- Extraction (combinational, per channel, on input side), evaluated in priority order:
  - message_en=0: field=DEFAULT, hit=0.
  - code==TYPE_A: slice at A_LSB, hit=1.
  - code==TYPE_D: slice at D_LSB, hit=1.
  - code==TYPE_K: slice at K_LSB, hit=1.
  - code==TYPE_Q: slice at Q_LSB, hit=1.
  - otherwise: DEFAULT, hit=0.
- Every channel extracts only from its own message. There is no cross-channel sourcing.
- FIFO, per channel, 2 entries of {field, hit}:
  - in_ready = (occupancy < 2) and not rst.
  - Enqueue on in_valid & in_ready at the clock edge.
  - out_valid = (occupancy != 0); field_bus and field_hit present the head entry and are held stable while out_valid & !out_ready.
  - Dequeue on out_valid & out_ready.
- Latency: a message accepted at edge k appears on out_valid after edge k (1 cycle) if the FIFO was empty.
- Ordering is preserved per channel. Channels are fully independent.
- Simultaneous enqueue and dequeue:
  - occupancy 1: stays 1, new entry becomes head on that edge.
  - occupancy 0: impossible, since out_valid=0.
  - occupancy 2: impossible, since in_ready=0.
- Empty FIFO: field_bus holds its last value and field_hit holds its last value. Consumers qualify with out_valid.
- Counters, per channel, updated on enqueue:
  - hit=1: hit counter +1.
  - message_en=1 and unknown code: miss counter +1.
  - message_en=0: neither counter changes.
  - Both counters saturate at 2^CNT_W-1, with no wrap.
  - cnt_clr has priority: an enqueue in the same cycle as cnt_clr leaves the counter at 0.
- Width rules: x_LSB+FIELD_BITS <= MSG_BITS is required for all four slices. The block is not specified for violating parameter sets.

Test Plan:
- Basic extract: ch0 code=TYPE_A, ch1=TYPE_K, ch2=TYPE_Q, all out_ready=1, message_en=1 -> one cycle later each out_valid=1 with its own channel's slice, field_hit=111; hit_cnt=1,1,1.
- Unknown code / disabled: ch1 code not a/d/k/q -> field=DEFAULT, hit=0, miss_cnt[1]=1. Then message_en=0 with TYPE_D -> DEFAULT, hit=0, both counters unchanged.
- Backpressure: out_ready[0]=0, three back-to-back valid messages M0,M1,M2 -> M0,M1 accepted, in_ready[0]=0 holds M2. Raise out_ready -> outputs in order M0,M1,M2, with field_bus stable during stall.
- Simultaneous enqueue/dequeue at occupancy 1 for 10 cycles -> one output per cycle, in_ready stays 1, no loss or duplication.
- Saturation and clear: CNT_W=4, 20 TYPE_A accepts -> hit_cnt=15. Assert cnt_clr in the same cycle as an accept -> 0.
- Async reset mid-stream: assert rst between edges with 2 entries buffered -> out_valid, in_ready, field_bus and counters go 0 immediately. After release, first output is the first message accepted post-reset.

Source files
------------

// File: rtl/stage5_field_extract_pipe.sv
// stage5_field_extract_pipe: per-channel type-coded field extractor with 2-entry skid FIFOs and hit/miss counters.
module stage5_field_extract_pipe #(
    parameter int NUM_CH = 3,
    parameter int MSG_BITS = 64,
    parameter int CTRL_W = 3,
    parameter int FIELD_BITS = 8,
    parameter int A_LSB = 0,
    parameter int D_LSB = 8,
    parameter int K_LSB = 16,
    parameter int Q_LSB = 24,
    parameter logic [CTRL_W-1:0] TYPE_A = 1,
    parameter logic [CTRL_W-1:0] TYPE_D = 2,
    parameter logic [CTRL_W-1:0] TYPE_K = 3,
    parameter logic [CTRL_W-1:0] TYPE_Q = 4,
    parameter logic [FIELD_BITS-1:0] DEFAULT = '0,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         message_en,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    input  logic [NUM_CH*MSG_BITS-1:0]   message_bus,
    input  logic [NUM_CH*CTRL_W-1:0]     mux_control_bus,
    output logic [NUM_CH-1:0]            out_valid,
    input  logic [NUM_CH-1:0]            out_ready,
    output logic [NUM_CH*FIELD_BITS-1:0] field_bus,
    output logic [NUM_CH-1:0]            field_hit,
    input  logic                         cnt_clr,
    output logic [NUM_CH*CNT_W-1:0]      hit_cnt_bus,
    output logic [NUM_CH*CNT_W-1:0]      miss_cnt_bus
);
    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            logic [MSG_BITS-1:0]   msg;
            logic [CTRL_W-1:0]     code;
            logic [FIELD_BITS-1:0] ext_field;
            logic                  ext_hit;
            logic [1:0]            occ;
            logic [FIELD_BITS:0]   head, tail;
            logic                  push, pop;
            logic [CNT_W-1:0]      hit_cnt, miss_cnt;
            assign msg  = message_bus[i*MSG_BITS +: MSG_BITS];
            assign code = mux_control_bus[i*CTRL_W +: CTRL_W];
            always_comb begin
                ext_hit   = message_en && (code == TYPE_A || code == TYPE_D || code == TYPE_K || code == TYPE_Q);
                ext_field = !message_en      ? DEFAULT :
                            (code == TYPE_A) ? msg[A_LSB +: FIELD_BITS] :
                            (code == TYPE_D) ? msg[D_LSB +: FIELD_BITS] :
                            (code == TYPE_K) ? msg[K_LSB +: FIELD_BITS] :
                            (code == TYPE_Q) ? msg[Q_LSB +: FIELD_BITS] : DEFAULT;
            end
            assign in_ready[i]  = ~rst & ~occ[1];
            assign out_valid[i] = |occ;
            assign push = in_valid[i] & in_ready[i];
            assign pop  = out_valid[i] & out_ready[i];
            assign field_bus[i*FIELD_BITS +: FIELD_BITS] = head[FIELD_BITS-1:0];
            assign field_hit[i] = head[FIELD_BITS];
            assign hit_cnt_bus[i*CNT_W +: CNT_W]  = hit_cnt;
            assign miss_cnt_bus[i*CNT_W +: CNT_W] = miss_cnt;
            // head is the output register; it is only overwritten by a new head so an empty FIFO keeps the last value
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    occ  <= '0;
                    head <= '0;
                    tail <= '0;
                end else begin
                    occ <= occ + {1'b0, push} - {1'b0, pop};
                    if (push && (occ == 2'd0 || (occ == 2'd1 && pop)))
                        head <= {ext_hit, ext_field};
                    else if (pop && occ == 2'd2)
                        head <= tail;
                    if (push && occ == 2'd1 && !pop)
                        tail <= {ext_hit, ext_field};
                end
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hit_cnt  <= '0;
                    miss_cnt <= '0;
                end else if (cnt_clr) begin
                    hit_cnt  <= '0;
                    miss_cnt <= '0;
                end else if (push) begin
                    if (ext_hit && hit_cnt != '1)
                        hit_cnt <= hit_cnt + CNT_W'(1);
                    if (message_en && !ext_hit && miss_cnt != '1)
                        miss_cnt <= miss_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_stage5_field_extract_pipe.sv
// tb_stage5_field_extract_pipe: randomized and directed scoreboard bench for stage5_field_extract_pipe.
module tb_stage5_field_extract_pipe;
    localparam int NUM_CH = 3;
    localparam int MB = 32;
    localparam int CW = 3;
    localparam int FB = 8;
    localparam int CNT_W = 4;
    localparam logic [FB-1:0] DEF = 8'hA5;
    localparam int SAT = (1 << CNT_W) - 1;

    logic clk = 0, rst = 1, message_en = 0, cnt_clr = 0;
    logic [NUM_CH-1:0] in_valid = '0, in_ready, out_valid, out_ready = '0, field_hit;
    logic [NUM_CH*MB-1:0] message_bus = '0;
    logic [NUM_CH*CW-1:0] mux_control_bus = '0;
    logic [NUM_CH*FB-1:0] field_bus;
    logic [NUM_CH*CNT_W-1:0] hit_cnt_bus, miss_cnt_bus;

    stage5_field_extract_pipe #(
        .NUM_CH(NUM_CH), .MSG_BITS(MB), .CTRL_W(CW), .FIELD_BITS(FB),
        .A_LSB(0), .D_LSB(8), .K_LSB(16), .Q_LSB(24),
        .TYPE_A(3'd1), .TYPE_D(3'd2), .TYPE_K(3'd3), .TYPE_Q(3'd4),
        .DEFAULT(DEF), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .message_en(message_en), .in_valid(in_valid), .in_ready(in_ready),
        .message_bus(message_bus), .mux_control_bus(mux_control_bus), .out_valid(out_valid),
        .out_ready(out_ready), .field_bus(field_bus), .field_hit(field_hit), .cnt_clr(cnt_clr),
        .hit_cnt_bus(hit_cnt_bus), .miss_cnt_bus(miss_cnt_bus)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [FB:0] sb[NUM_CH][$];
    int mh[NUM_CH], mm[NUM_CH];
    logic [NUM_CH-1:0] stalled = '0;
    logic [FB:0] held[NUM_CH];

    function automatic logic [FB:0] ref_ext(logic en, logic [CW-1:0] code, logic [MB-1:0] msg);
        int lsb;
        lsb = -1;
        if (en) begin
            case (code)
                3'd1: lsb = 0;
                3'd2: lsb = 8;
                3'd3: lsb = 16;
                3'd4: lsb = 24;
                default: lsb = -1;
            endcase
        end
        if (lsb < 0) return {1'b0, DEF};
        return {1'b1, FB'(msg >> lsb)};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Input-side scoreboard: state checks before this edge's pushes, then predicted entries and counters.
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                chk($sformatf("hit_cnt[%0d]", c), 64'(hit_cnt_bus[c*CNT_W +: CNT_W]), 64'(mh[c]));
                chk($sformatf("miss_cnt[%0d]", c), 64'(miss_cnt_bus[c*CNT_W +: CNT_W]), 64'(mm[c]));
                chk($sformatf("in_ready[%0d]", c), 64'(in_ready[c]), 64'(sb[c].size() < 2));
                chk($sformatf("out_valid[%0d]", c), 64'(out_valid[c]), 64'(sb[c].size() != 0));
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (in_valid[c] && in_ready[c]) begin
                    logic [FB:0] e;
                    e = ref_ext(message_en, mux_control_bus[c*CW +: CW], message_bus[c*MB +: MB]);
                    sb[c].push_back(e);
                    if (!cnt_clr) begin
                        if (e[FB]) mh[c] = (mh[c] < SAT) ? mh[c] + 1 : SAT;
                        else if (message_en) mm[c] = (mm[c] < SAT) ? mm[c] + 1 : SAT;
                    end
                end
                if (cnt_clr) begin
                    mh[c] = 0;
                    mm[c] = 0;
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on each output handshake and checks hold-stability under stall.
    always begin
        @(negedge clk);
        #1;
        if (rst) stalled = '0;
        else begin
            for (int c = 0; c < NUM_CH; c++) begin
                logic [FB:0] act;
                act = {field_hit[c], field_bus[c*FB +: FB]};
                if (out_valid[c]) begin
                    if (stalled[c]) chk($sformatf("stall_hold[%0d]", c), 64'(act), 64'(held[c]));
                    if (out_ready[c]) begin
                        if (sb[c].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_out[%0d]: got %0h expected no output", c, act);
                        end else begin
                            chk($sformatf("out[%0d]", c), 64'(act), 64'(sb[c].pop_front()));
                        end
                    end
                    stalled[c] = !out_ready[c];
                    held[c] = act;
                end else stalled[c] = 0;
            end
        end
    end

    task automatic drive(int c, logic v, logic [CW-1:0] code, logic [MB-1:0] msg);
        in_valid[c] = v;
        mux_control_bus[c*CW +: CW] = code;
        message_bus[c*MB +: MB] = msg;
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            mh[c] = 0;
            mm[c] = 0;
        end
        #1;
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_field_bus", 64'(field_bus), 0);
        chk("rst_hit_cnt", 64'(hit_cnt_bus), 0);
        @(posedge clk);
        #2 rst = 0;
        #1 chk("post_rst_in_ready", 64'(in_ready), 64'(3'b111));
        // basic extract, one type per channel
        cyc();
        message_en = 1;
        out_ready = '1;
        drive(0, 1, 3'd1, 32'h44332211);
        drive(1, 1, 3'd3, 32'h88776655);
        drive(2, 1, 3'd4, 32'hCCBBAA99);
        cyc();
        in_valid = '0;
        chk("basic_out_valid", 64'(out_valid), 64'(3'b111));
        chk("basic_field_hit", 64'(field_hit), 64'(3'b111));
        chk("basic_field_bus", 64'(field_bus), 64'(24'hCC_77_11));
        // unknown code, then disabled extraction
        drive(1, 1, 3'd6, 32'h12345678);
        cyc();
        message_en = 0;
        drive(1, 1, 3'd2, 32'h12345678);
        cyc();
        in_valid = '0;
        message_en = 1;
        cyc();
        // backpressure on channel 0
        out_ready[0] = 0;
        drive(0, 1, 3'd2, 32'h0000A000);
        cyc();
        drive(0, 1, 3'd2, 32'h0000B100);
        cyc();
        drive(0, 1, 3'd2, 32'h0000C200);
        cyc();
        chk("bp_in_ready0", 64'(in_ready[0]), 0);
        cyc();
        out_ready[0] = 1;
        cyc();
        cyc();
        in_valid[0] = 0;
        repeat (3) cyc();
        // simultaneous enqueue/dequeue at occupancy 1
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 3'($urandom_range(1, 4)), $urandom);
            cyc();
            chk("stream_in_ready0", 64'(in_ready[0]), 1);
        end
        in_valid[0] = 0;
        cyc();
        // saturation and clear priority
        for (int k = 0; k < 20; k++) begin
            drive(0, 1, 3'd1, $urandom);
            cyc();
        end
        in_valid[0] = 0;
        cyc();
        chk("sat_hit_cnt0", 64'(hit_cnt_bus[CNT_W-1:0]), 64'(SAT));
        drive(0, 1, 3'd1, $urandom);
        cnt_clr = 1;
        cyc();
        cnt_clr = 0;
        in_valid[0] = 0;
        chk("clr_hit_cnt0", 64'(hit_cnt_bus[CNT_W-1:0]), 0);
        cyc();
        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            message_en = ($urandom_range(0, 9) != 0);
            cnt_clr = ($urandom_range(0, 39) == 0);
            out_ready = NUM_CH'($urandom);
            for (int c = 0; c < NUM_CH; c++)
                drive(c, 1'($urandom), 3'($urandom_range(0, 7)), $urandom);
            cyc();
        end
        in_valid = '0;
        cnt_clr = 0;
        message_en = 1;
        cyc();
        // asynchronous reset with entries buffered
        out_ready = '0;
        for (int c = 0; c < NUM_CH; c++) drive(c, 1, 3'd3, $urandom);
        cyc();
        cyc();
        in_valid = '0;
        @(posedge clk);
        #3 rst = 1;
        for (int c = 0; c < NUM_CH; c++) begin
            sb[c].delete();
            mh[c] = 0;
            mm[c] = 0;
        end
        #1;
        chk("arst_out_valid", 64'(out_valid), 0);
        chk("arst_in_ready", 64'(in_ready), 0);
        chk("arst_field_bus", 64'(field_bus), 0);
        chk("arst_hit_cnt", 64'(hit_cnt_bus), 0);
        chk("arst_miss_cnt", 64'(miss_cnt_bus), 0);
        @(posedge clk);
        #2 rst = 0;
        cyc();
        out_ready = '1;
        drive(0, 1, 3'd4, 32'h5A000000);
        cyc();
        in_valid = '0;
        chk("post_arst_first", 64'({field_hit[0], field_bus[FB-1:0]}), 64'({1'b1, 8'h5A}));
        // drain with bounded wait
        out_ready = '1;
        for (int k = 0; k < 50 && (sb[0].size() + sb[1].size() + sb[2].size()) != 0; k++) cyc();
        chk("drain_empty", 64'(sb[0].size() + sb[1].size() + sb[2].size()), 0);
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
